// File: rtl/seg_digit_scanner.sv
// Time-multiplexed scan driver for an N-digit 7-segment display with tear-free frame-boundary commit.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seg_digit_scanner #(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load_in,
    output logic [3:0]              digit_out,
    output logic [NUM_DIGITS-1:0]   anode_out,
    output logic                    dp_out,
    output logic [2:0]              idx_out,
    output logic                    pending_out
);

    localparam int             PW   = $clog2(REFRESH_DIV + 1);
    localparam logic [PW-1:0]  PMAX = PW'(REFRESH_DIV - 1);
    localparam logic [2:0]     IMAX = 3'(NUM_DIGITS - 1);

    logic [PW-1:0]           pcnt;
    logic [2:0]              idx;
    logic [4*NUM_DIGITS-1:0] disp;
    logic [4*NUM_DIGITS-1:0] pend;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pending;
    logic                    tick;
    logic                    fb;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   onehot;

    assign tick = (pcnt == PMAX);
    assign fb   = tick && (idx == IMAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt    <= '0;
            idx     <= '0;
            disp    <= '0;
            disp_dp <= '0;
            pend    <= '0;
            pend_dp <= '0;
            pending <= 1'b0;
        end else begin
            if (tick) begin
                pcnt <= '0;
                idx  <= (idx == IMAX) ? 3'd0 : idx + 3'd1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
            // The display only changes on the frame boundary so a frame is never torn.
            if (fb) begin
                if (load_in) begin
                    disp    <= value_in;
                    disp_dp <= dp_in;
                end else if (pending) begin
                    disp    <= pend;
                    disp_dp <= pend_dp;
                end
                pending <= 1'b0;
            end else if (load_in) begin
                pend    <= value_in;
                pend_dp <= dp_in;
                pending <= 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_zero;

    // Walk from the most significant digit down; a digit blanks while everything above it is zero.
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (disp[4*k +: 4] == 4'd0);
            blank[k]   = upper_zero && !disp_dp[k];
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        digit_out = 4'd0;
        dp_out    = 1'b0;
        onehot    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == 3'(k)) begin
                digit_out = disp[4*k +: 4];
                dp_out    = disp_dp[k];
                onehot[k] = !blank[k];
            end
        end
    end

    assign anode_out   = (ANODE_ACTIVE_LOW != 0) ? ~onehot : onehot;
    assign idx_out     = idx;
    assign pending_out = pending;

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Self-checking bench for seg_digit_scanner (N=4, REFRESH_DIV=4, active-low anodes): table vectors,
// hand-written corner sequences and randomized traffic against a time-based reference model.
module tb_seg_digit_scanner;

    localparam int N  = 4;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load_in = 1'b0;
    logic [3:0]  digit_out;
    logic [3:0]  anode_out;
    logic        dp_out;
    logic [2:0]  idx_out;
    logic        pending_out;

    seg_digit_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .ANODE_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .load_in(load_in),
        .digit_out(digit_out), .anode_out(anode_out), .dp_out(dp_out),
        .idx_out(idx_out), .pending_out(pending_out)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    // Reference model: position in the scan derived from cycles elapsed since reset.
    int          cyc = 0;
    logic [15:0] mdisp = '0, mpend = '0;
    logic [3:0]  mdp = '0, mpdp = '0;
    logic        mpending = 1'b0;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [15:0] exp_dig;
        logic [15:0] an_plain;
        logic [15:0] an_blank;
        logic [3:0]  exp_dpo;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_anode(input int i, input logic [15:0] d, input logic [3:0] p);
        logic [3:0] on;
        on = 4'b0001 << i;
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && (d >> (4 * i)) == 16'd0 && !p[i]) on = 4'b0000;
`endif
        return ~on;
    endfunction

    task automatic step();
        logic fb;
        int   i;
        @(posedge clk);
        if (rst) begin
            cyc = 0; mdisp = '0; mdp = '0; mpend = '0; mpdp = '0; mpending = 1'b0;
        end else begin
            fb = ((cyc % RD) == RD - 1) && (((cyc / RD) % N) == N - 1);
            if (fb) begin
                if (load_in) begin mdisp = value_in; mdp = dp_in; end
                else if (mpending) begin mdisp = mpend; mdp = mpdp; end
                mpending = 1'b0;
            end else if (load_in) begin
                mpend = value_in; mpdp = dp_in; mpending = 1'b1;
            end
            cyc++;
        end
        #1;
        i = (cyc / RD) % N;
        chk("model", {17'd0, digit_out, dp_out, idx_out, anode_out, pending_out},
            {17'd0, 4'((mdisp >> (4 * i)) & 16'hF), mdp[i], 3'(i), exp_anode(i, mdisp, mdp), mpending});
    endtask

    task automatic run_until(input int c);
        for (int b = 0; b < 200 && cyc < c; b++) step();
    endtask

    task automatic reset_dut();
        rst = 1'b1; load_in = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic load_one(input logic [15:0] v, input logic [3:0] p);
        value_in = v; dp_in = p; load_in = 1'b1;
        step();
        load_in = 1'b0;
    endtask

    initial begin
        logic saw;
        logic [15:0] an;

        tbl[0] = '{16'h1234, 4'h0, 16'h1234, 16'h7BDE, 16'h7BDE, 4'h0};
        tbl[1] = '{16'h0070, 4'h0, 16'h0070, 16'h7BDE, 16'hFFDE, 4'h0};
        tbl[2] = '{16'h0000, 4'h0, 16'h0000, 16'h7BDE, 16'hFFFE, 4'h0};
        tbl[3] = '{16'h0F00, 4'h8, 16'h0F00, 16'h7BDE, 16'h7BDE, 4'h8};
        tbl[4] = '{16'hA05C, 4'h2, 16'hA05C, 16'h7BDE, 16'h7BDE, 4'h2};
        tbl[5] = '{16'h0001, 4'h4, 16'h0001, 16'h7BDE, 16'hFBFE, 4'h4};

        // Reset held for three cycles, then scan timing after release.
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_anode", 32'(anode_out), 32'hE);
            chk("rst_digit", 32'(digit_out), 32'h0);
            chk("rst_pending", 32'(pending_out), 32'h0);
        end
        rst = 1'b0;
        run_until(3);
        chk("rel_slot0_end", 32'(anode_out), 32'h E);
        step();
        chk("rel_slot1", 32'(anode_out), 32'h D);
        run_until(16);
        chk("rel_frame_wrap", 32'(anode_out), 32'h E);

        // Table: mid-frame load, then check every slot of the committed frame.
        for (int r = 0; r < 6; r++) begin
            reset_dut();
            run_until(5);
            load_one(tbl[r].val, tbl[r].dp);
            chk("tbl_pending_set", 32'(pending_out), 32'h1);
            run_until(15);
            chk("tbl_pending_hold", 32'(pending_out), 32'h1);
            step();
            chk("tbl_pending_clr", 32'(pending_out), 32'h0);
`ifdef LEADING_ZERO_BLANK_EN
            an = tbl[r].an_blank;
`else
            an = tbl[r].an_plain;
`endif
            for (int k = 0; k < N; k++) begin
                run_until(16 + 4 * k + 2);
                chk("tbl_digit", 32'(digit_out), 32'(tbl[r].exp_dig[4*k +: 4]));
                chk("tbl_anode", 32'(anode_out), 32'(an[4*k +: 4]));
                chk("tbl_dp", 32'(dp_out), 32'(tbl[r].exp_dpo[k]));
            end
        end

        // Last load within a frame wins; the earlier value never reaches the display.
        reset_dut();
        run_until(3);
        load_one(16'hAAAA, 4'h0);
        run_until(9);
        load_one(16'h5555, 4'h0);
        saw = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (digit_out == 4'hA) saw = 1'b1;
        end
        chk("lastwins_noA", 32'(saw), 32'h0);
        chk("lastwins_digit", 32'(digit_out), 32'h5);

        // Load exactly on the frame-boundary cycle commits directly.
        reset_dut();
        run_until(15);
        load_one(16'hBEEF, 4'h0);
        chk("fbload_pending", 32'(pending_out), 32'h0);
        chk("fbload_digit", 32'(digit_out), 32'hF);
        chk("fbload_anode", 32'(anode_out), 32'hE);

        // Reset while a value is pending discards it.
        reset_dut();
        run_until(2);
        load_one(16'h9999, 4'h0);
        run_until(8);
        chk("rstpend_before", 32'(pending_out), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstpend_pending", 32'(pending_out), 32'h0);
        chk("rstpend_idx", 32'(idx_out), 32'h0);
        saw = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (digit_out != 4'h0 || pending_out) saw = 1'b1;
        end
        chk("rstpend_zeros", 32'(saw), 32'h0);

        // Randomized traffic checked cycle by cycle against the model.
        for (int k = 0; k < 3000; k++) begin
            rst      = ($urandom_range(0, 99) == 0);
            load_in  = ($urandom_range(0, 5) == 0);
            value_in = 16'($urandom);
            dp_in    = 4'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
